// File: rtl/invader_formation.sv
// Enemy formation controller: owns the alive bitmap and the formation offset, marches the
// block sideways with drops at the screen edges, resolves hits and answers per-pixel queries.
module invader_formation #(
  parameter int COLS        = 8,
  parameter int ROWS        = 3,
  parameter int ORIGIN_X    = 40,
  parameter int ORIGIN_Y    = 40,
  parameter int PITCH_X     = 60,
  parameter int PITCH_Y     = 50,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 24,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 16,
  parameter int X_MAX       = 639,
  parameter int LAND_Y      = 440,
  parameter int MOVE_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  input  logic       hit_valid,
  input  logic [2:0] hit_row,
  input  logic [3:0] hit_col,
  output logic       hit_ack,
  output logic       pixel_on,
  output logic [2:0] pixel_row,
  output logic [9:0] off_x,
  output logic [9:0] off_y,
  output logic [6:0] alive_count,
  output logic       all_dead,
  output logic       landed
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_FRAMES - 1);

  typedef enum logic [1:0] {MARCH_R, MARCH_L, LANDED} march_e;

  logic [N-1:0]       alive_q, alive_d, hit_mask;
  logic [9:0]         off_x_q, off_y_q;
  march_e             state_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic               move_now_q;
  logic               hit_ack_q, pixel_on_q, all_dead_q, landed_q;
  logic [2:0]         pixel_row_q;
  logic [6:0]         alive_count_q;

  logic [COLS-1:0]    col_alive, col_hit;
  logic [ROWS-1:0]    row_alive, row_hit;
  logic [10:0]        right_base, left_base, bottom_base;
  logic [10:0]        right_edge, left_edge;
  logic [9:0]         off_y_drop;
  logic               drop_r, drop_l, land_hit;
  logic [7:0]         alive_count_d;
  logic               pixel_on_d;
  logic [2:0]         pixel_row_d;

  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    col_alive = '0;
    row_alive = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_q[r*COLS + c]) begin
          col_alive[c] = 1'b1;
          row_alive[r] = 1'b1;
        end
      end
    end
  end

  // Extreme live columns/rows come straight from the current bitmap, so kills shift the edges at once.
  always_comb begin
    right_base  = '0;
    left_base   = '0;
    bottom_base = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_alive[c]) right_base = 11'(ORIGIN_X + c*PITCH_X + SPR_W - 1);
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_alive[c]) left_base = 11'(ORIGIN_X + c*PITCH_X);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_alive[r]) bottom_base = 11'(ORIGIN_Y + r*PITCH_Y + SPR_H - 1);
    end
    right_edge = right_base + {1'b0, off_x_q};
    left_edge  = left_base + {1'b0, off_x_q};
    off_y_drop = off_y_q + 10'(STEP_Y);
    drop_r     = (right_edge + 11'(STEP_X)) > 11'(X_MAX);
    drop_l     = (off_x_q < 10'(STEP_X)) || (left_edge < 11'(STEP_X));
    land_hit   = (bottom_base + {1'b0, off_y_drop}) >= 11'(LAND_Y);
  end

  // Out-of-range indices simply match no invader, so they fall through as misses.
  always_comb begin
    hit_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        hit_mask[r*COLS + c] = hit_valid && (hit_row == 3'(r)) && (hit_col == 4'(c))
                               && alive_q[r*COLS + c];
      end
    end
    alive_d       = alive_q & ~hit_mask;
    alive_count_d = '0;
    for (int i = 0; i < N; i++) begin
      alive_count_d = alive_count_d + 8'(alive_d[i]);
    end
  end

  // A sprite box is the crossing of a column band and a row band; scanning rows downwards
  // lets the lowest row index take the final write when boxes overlap.
  always_comb begin
    logic [10:0] scan_x, scan_y, lo;
    scan_x = {1'b0, h_counter};
    scan_y = {1'b0, v_counter};
    for (int c = 0; c < COLS; c++) begin
      lo         = 11'(ORIGIN_X + c*PITCH_X) + {1'b0, off_x_q};
      col_hit[c] = (scan_x >= lo) && (scan_x <= lo + 11'(SPR_W - 1));
    end
    for (int r = 0; r < ROWS; r++) begin
      lo         = 11'(ORIGIN_Y + r*PITCH_Y) + {1'b0, off_y_q};
      row_hit[r] = (scan_y >= lo) && (scan_y <= lo + 11'(SPR_H - 1));
    end
    pixel_on_d  = 1'b0;
    pixel_row_d = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      for (int c = 0; c < COLS; c++) begin
        if (row_hit[r] && col_hit[c] && alive_q[r*COLS + c]) begin
          pixel_on_d  = 1'b1;
          pixel_row_d = 3'(r);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register here
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the alive bitmap is a plain register vector, not a RAM, so it can and must
      // take a defined reset value.
      alive_q       <= '1;
      off_x_q       <= '0;
      off_y_q       <= '0;
      state_q       <= MARCH_R;
      frame_cnt_q   <= '0;
      move_now_q    <= 1'b0;
      hit_ack_q     <= 1'b0;
      pixel_on_q    <= 1'b0;
      pixel_row_q   <= '0;
      alive_count_q <= 7'(N);
      all_dead_q    <= 1'b0;
      landed_q      <= 1'b0;
    end else begin
      alive_q       <= alive_d;
      hit_ack_q     <= |hit_mask;
      alive_count_q <= 7'(alive_count_d);
      all_dead_q    <= (alive_count_d == '0);
      pixel_on_q    <= pixel_on_d;
      pixel_row_q   <= pixel_row_d;

      move_now_q <= 1'b0;
      if (frame_tick) begin
        if (frame_cnt_q == CNT_LAST) begin
          frame_cnt_q <= '0;
          move_now_q  <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end

      // Edge checks read the pre-hit bitmap; an empty formation stays frozen.
      if (move_now_q && |alive_q) begin
        unique case (state_q)
          MARCH_R: begin
            if (drop_r) begin
              off_y_q  <= off_y_drop;
              state_q  <= land_hit ? LANDED : MARCH_L;
              landed_q <= land_hit;
            end else begin
              off_x_q <= off_x_q + 10'(STEP_X);
            end
          end
          MARCH_L: begin
            if (drop_l) begin
              off_y_q  <= off_y_drop;
              state_q  <= land_hit ? LANDED : MARCH_R;
              landed_q <= land_hit;
            end else begin
              off_x_q <= off_x_q - 10'(STEP_X);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hit_ack     = hit_ack_q;
  assign pixel_on    = pixel_on_q;
  assign pixel_row   = pixel_row_q;
  assign off_x       = off_x_q;
  assign off_y       = off_y_q;
  assign alive_count = alive_count_q;
  assign all_dead    = all_dead_q;
  assign landed      = landed_q;

endmodule

// File: tb/tb_invader_formation.sv
// Bench for invader_formation: a geometric model of the formation is stepped alongside the DUT
// every clock, and directed plus randomized scenarios compare outputs against it.
module tb_invader_formation;

  localparam int COLS = 8, ROWS = 3, OX = 40, OY = 40, PX = 60, PY = 50, SW = 32, SH = 24;
  localparam int SX = 8, SY = 16, XMAX = 639, LANDY = 440, MF = 2;

  logic       clk = 1'b0;
  logic       reset, frame_tick, hit_valid;
  logic [9:0] h_counter, v_counter;
  logic [2:0] hit_row;
  logic [3:0] hit_col;
  logic       hit_ack, pixel_on, all_dead, landed;
  logic [2:0] pixel_row;
  logic [9:0] off_x, off_y;
  logic [6:0] alive_count;
  logic [33:0] dut_vec;

  always #5 clk = ~clk;

  invader_formation #(
    .COLS(COLS), .ROWS(ROWS), .ORIGIN_X(OX), .ORIGIN_Y(OY), .PITCH_X(PX), .PITCH_Y(PY),
    .SPR_W(SW), .SPR_H(SH), .STEP_X(SX), .STEP_Y(SY), .X_MAX(XMAX), .LAND_Y(LANDY),
    .MOVE_FRAMES(MF)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .h_counter(h_counter),
    .v_counter(v_counter), .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .hit_ack(hit_ack), .pixel_on(pixel_on), .pixel_row(pixel_row), .off_x(off_x),
    .off_y(off_y), .alive_count(alive_count), .all_dead(all_dead), .landed(landed)
  );

  assign dut_vec = {hit_ack, pixel_on, pixel_row, off_x, off_y, alive_count, all_dead, landed};

  int n_checks = 0;
  int n_errors = 0;

  // Model: direction 0 = marching right, 1 = marching left, 2 = landed.
  bit m_alive [ROWS][COLS];
  int m_offx, m_offy, m_state, m_ticks, m_count, m_prow;
  bit m_move, m_ack, m_pix, m_landed;

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_alive[r][c] = 1'b1;
    m_offx = 0; m_offy = 0; m_state = 0; m_ticks = 0; m_count = ROWS * COLS;
    m_move = 0; m_ack = 0; m_pix = 0; m_prow = 0; m_landed = 0;
  endfunction

  function automatic logic [33:0] model_vec();
    return {m_ack, m_pix, 3'(m_prow), 10'(m_offx), 10'(m_offy), 7'(m_count),
            (m_count == 0), m_landed};
  endfunction

  function automatic void model_step(bit tick, bit hv, int hr, int hc, int hx, int vy);
    int maxc = -1, minc = COLS, maxr = -1;
    m_pix = 0; m_prow = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!m_pix && m_alive[r][c] &&
            hx >= OX + c*PX + m_offx && hx <= OX + c*PX + m_offx + SW - 1 &&
            vy >= OY + r*PY + m_offy && vy <= OY + r*PY + m_offy + SH - 1) begin
          m_pix = 1; m_prow = r;
        end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_alive[r][c]) begin
          if (c > maxc) maxc = c;
          if (c < minc) minc = c;
          if (r > maxr) maxr = r;
        end
    if (m_move && m_count > 0 && m_state != 2) begin
      bit dropped = 0;
      if (m_state == 0) begin
        if (OX + maxc*PX + SW - 1 + m_offx + SX > XMAX) begin
          m_offy += SY; m_state = 1; dropped = 1;
        end else m_offx += SX;
      end else begin
        if (m_offx < SX || OX + minc*PX + m_offx - SX < 0) begin
          m_offy += SY; m_state = 0; dropped = 1;
        end else m_offx -= SX;
      end
      if (dropped && OY + maxr*PY + SH - 1 + m_offy >= LANDY) begin
        m_state = 2; m_landed = 1;
      end
    end
    m_move = 0;
    if (tick) begin
      m_ticks++;
      if (m_ticks == MF) begin m_ticks = 0; m_move = 1; end
    end
    m_ack = 0;
    if (hv && hr < ROWS && hc < COLS && m_alive[hr][hc]) begin
      m_alive[hr][hc] = 0; m_ack = 1;
    end
    m_count = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_count += int'(m_alive[r][c]);
  endfunction

  task automatic cycle(input bit tick, input bit hv, input int hr, input int hc,
                       input int hx, input int vy);
    frame_tick = tick; hit_valid = hv; hit_row = 3'(hr); hit_col = 4'(hc);
    h_counter = 10'(hx); v_counter = 10'(vy);
    model_step(tick, hv, hr, hc, hx, vy);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pair();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input bit busy);
    reset = 1'b1; frame_tick = busy; hit_valid = busy; hit_row = 3'd0; hit_col = 4'd0;
    h_counter = 10'd40; v_counter = 10'd40;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0;
  endtask

  localparam logic [33:0] RESET_VEC = {1'b0, 1'b0, 3'd0, 10'd0, 10'd0, 7'd24, 1'b0, 1'b0};

  task automatic test_reset();
    do_reset(1);
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_errors++; $display("FAIL reset_state got=%h want=%h", dut_vec, RESET_VEC);
    end
  endtask

  task automatic test_pixel_probe();
    int px [6] = '{40, 71, 72, 40, 100, 40};
    int py [6] = '{40, 63, 40, 90, 163, 64};
    bit eon [6] = '{1, 1, 0, 1, 1, 0};
    int erow [6] = '{0, 0, 0, 1, 2, 0};
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, px[i], py[i]);
      n_checks++;
      if (pixel_on !== eon[i] || pixel_row !== 3'(erow[i])) begin
        n_errors++;
        $display("FAIL pixel_probe(%0d,%0d) got on=%b row=%0d want on=%b row=%0d",
                 px[i], py[i], pixel_on, pixel_row, eon[i], erow[i]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      int r = $urandom_range(0, ROWS - 1), c = $urandom_range(0, COLS - 1);
      cycle(0, 0, 0, 0, OX + c*PX + $urandom_range(0, SW + 3) - 2,
            OY + r*PY + $urandom_range(0, SH + 3) - 2);
      n_checks++;
      if (pixel_on !== m_pix || pixel_row !== 3'(m_prow)) begin
        n_errors++;
        $display("FAIL pixel_random got on=%b row=%0d want on=%b row=%0d",
                 pixel_on, pixel_row, m_pix, m_prow);
      end
    end
  endtask

  task automatic test_move_timer();
    do_reset(0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (off_x !== 10'((k / 2) * SX) || off_y !== 10'd0) begin
        n_errors++;
        $display("FAIL move_timer tick%0d got x=%0d y=%0d want x=%0d y=0",
                 k, off_x, off_y, (k / 2) * SX);
      end
    end
  endtask

  task automatic march_to_drop(input string tag, input int want_x);
    for (int i = 0; i < 400 && m_state == 0; i++) begin
      tick_pair();
      n_checks++;
      if (off_x !== 10'(m_offx)) begin
        n_errors++; $display("FAIL %s_step got x=%0d want x=%0d", tag, off_x, m_offx);
      end
    end
    n_checks++;
    if (off_x !== 10'(want_x) || off_y !== 10'(SY) || m_state != 1) begin
      n_errors++;
      $display("FAIL %s_drop got x=%0d y=%0d want x=%0d y=%0d", tag, off_x, off_y, want_x, SY);
    end
  endtask

  task automatic test_march_drop();
    do_reset(0);
    march_to_drop("march", 144);
    tick_pair(); tick_pair();
    n_checks++;
    if (off_x !== 10'd136 || off_y !== 10'(SY)) begin
      n_errors++; $display("FAIL march_left got x=%0d y=%0d want x=136 y=16", off_x, off_y);
    end
  endtask

  task automatic test_kill_column();
    int acks = 0;
    do_reset(0);
    for (int r = 0; r < 4; r++) begin
      cycle(0, r < 3, r, 7, 0, 0);
      acks += int'(hit_ack);
    end
    n_checks++;
    if (acks != 3 || alive_count !== 7'd21) begin
      n_errors++; $display("FAIL kill_column got acks=%0d alive=%0d want 3/21", acks, alive_count);
    end
    march_to_drop("kill_col", 208);
  endtask

  task automatic test_dead_and_range();
    int hr [5] = '{1, 1, 5, 0, 0};
    int hc [5] = '{3, 3, 0, 9, 0};
    int acks = 0;
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, i < 4, hr[i], hc[i], 0, 0);
      acks += int'(hit_ack);
    end
    n_checks++;
    if (acks != 1 || alive_count !== 7'd23) begin
      n_errors++; $display("FAIL dead_range got acks=%0d alive=%0d want 1/23", acks, alive_count);
    end
    cycle(0, 0, 0, 0, 220 + m_offx, 90 + m_offy);
    n_checks++;
    if (pixel_on !== 1'b0) begin
      n_errors++; $display("FAIL dead_pixel got on=%b want on=0", pixel_on);
    end
    cycle(0, 0, 0, 0, 220, 140);
    n_checks++;
    if (pixel_on !== 1'b1 || pixel_row !== 3'd2) begin
      n_errors++; $display("FAIL live_pixel got on=%b row=%0d want on=1 row=2", pixel_on, pixel_row);
    end
  endtask

  task automatic test_all_dead();
    do_reset(0);
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) cycle(0, 1, r, c, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (alive_count !== 7'd0 || all_dead !== 1'b1 || hit_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL all_dead got alive=%0d dead=%b ack=%b want 0/1/0", alive_count, all_dead, hit_ack);
    end
    repeat (6) tick_pair();
    n_checks++;
    if (off_x !== 10'd0 || off_y !== 10'd0) begin
      n_errors++; $display("FAIL dead_frozen got x=%0d y=%0d want 0/0", off_x, off_y);
    end
  endtask

  task automatic test_random();
    do_reset(0);
    for (int i = 0; i < 800; i++) begin
      int r = $urandom_range(0, ROWS - 1), c = $urandom_range(0, COLS - 1);
      cycle($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 3),
            $urandom_range(0, 8), OX + c*PX + m_offx + $urandom_range(0, SW + 3) - 2,
            OY + r*PY + m_offy + $urandom_range(0, SH + 3) - 2);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++; $display("FAIL random cyc%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_landing_and_reset();
    logic [9:0] sx, sy;
    do_reset(0);
    for (int i = 0; i < 3000 && m_state != 2; i++) tick_pair();
    n_checks++;
    if (m_state != 2 || landed !== 1'b1 || off_y !== 10'd288 || off_x !== 10'(m_offx)) begin
      n_errors++;
      $display("FAIL landing got landed=%b x=%0d y=%0d want 1 x=%0d y=288", landed, off_x, off_y, m_offx);
    end
    sx = off_x; sy = off_y;
    repeat (6) tick_pair();
    n_checks++;
    if (off_x !== sx || off_y !== sy || landed !== 1'b1) begin
      n_errors++; $display("FAIL landed_frozen got x=%0d y=%0d want x=%0d y=%0d", off_x, off_y, sx, sy);
    end
    do_reset(1);
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_errors++; $display("FAIL reset_after_land got=%h want=%h", dut_vec, RESET_VEC);
    end
    repeat (5) tick_pair();
    for (int i = 0; i < 8 && !m_move; i++) cycle(1, 0, 0, 0, 0, 0);
    do_reset(1);
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_errors++; $display("FAIL reset_mid_march got=%h want=%h", dut_vec, RESET_VEC);
    end
    tick_pair();
    n_checks++;
    if (off_x !== 10'd0) begin
      n_errors++; $display("FAIL timer_after_reset got x=%0d want x=0", off_x);
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; hit_valid = 1'b0; hit_row = '0; hit_col = '0;
    h_counter = '0; v_counter = '0;
    model_reset();
    test_reset();
    test_pixel_probe();
    test_move_timer();
    test_march_drop();
    test_kill_column();
    test_dead_and_range();
    test_all_dead();
    test_random();
    test_landing_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
